mdr_mem_if: RTL and testbench
=============================

MDR_MEM_IF -- requirements
Module: mdr_mem_if

Interface
REQ-001 The module SHALL have a single clock and a reset that is asynchronous and active-high, with ports named clock and clear.
REQ-002 clock  input  1  rising-edge system clock.
REQ-003 clear  input  1  asynchronous active-high reset.
REQ-004 BusMuxOut  input  32  current bus value, source for MAR/MDR loads.
REQ-005 MARin  input  1  load MAR from BusMuxOut[8:0].
REQ-006 MDRin  input  1  load MDR from BusMuxOut.
REQ-007 Read  input  1  single-cycle request: memory read at MAR into MDR.
REQ-008 Write  input  1  single-cycle request: memory write of MDR to MAR.
REQ-009 mem_rdata  input  32  memory read data, valid when mem_ready=1 during a read.
REQ-010 mem_ready  input  1  memory completion strobe.
REQ-011 BusMuxInMDR  output  32  MDR contents, driven to the bus mux MDR input.
REQ-012 mem_addr  output  9  MAR contents.
REQ-013 mem_wdata  output  32  MDR contents.
REQ-014 mem_rd / mem_wr  output  1 each  memory request strobes.
REQ-015 busy  output  1  high while the FSM is in RD or WR.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 err  output  1  one-cycle timeout pulse, coincident with done.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR and FIN.
REQ-019 From IDLE, Read=1 SHALL go to RD on the next edge; else Write=1 SHALL go to WR; Read has priority and a simultaneous Write is dropped.
REQ-020 In RD, mem_rd SHALL be 1 and mem_wr 0; in WR, mem_wr SHALL be 1 and mem_rd 0; both strobes SHALL be 0 in IDLE and FIN (Moore, registered state decode).
REQ-021 In RD with mem_ready=1, MDR SHALL load mem_rdata at that edge and the FSM SHALL go to FIN.
REQ-022 In WR with mem_ready=1, the FSM SHALL go to FIN; MDR is unchanged.
REQ-023 In FIN, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; Read/Write seen in FIN SHALL be ignored.
REQ-024 Read/Write timing: request sampled at edge N gives strobe high from cycle N+1; mem_ready sampled at edge M gives done high in cycle M+1; minimum request-to-done is 2 cycles.
REQ-025 A 4-bit wait counter SHALL clear on entry to RD/WR and increment each cycle in RD/WR without mem_ready.
REQ-026 When the wait counter reaches TIMEOUT=15 without mem_ready, the FSM SHALL go to FIN with err=1 in the FIN cycle, and MDR SHALL be unchanged.
REQ-027 MARin and MDRin SHALL take effect only in IDLE or FIN; they SHALL be ignored while busy=1 so that mem_addr and mem_wdata stay stable for the whole transaction.
REQ-028 MDRin and a read completion SHALL never coincide by REQ-027; if MDRin and Read are both 1 in IDLE, MDR SHALL load the bus value and the read SHALL start, overwriting MDR on completion.
REQ-029 Read/Write asserted while busy SHALL be ignored (not queued).
REQ-030 mem_ready in IDLE or FIN SHALL be ignored.

Reset
REQ-031 clear=1 SHALL asynchronously force state IDLE, MAR=0, MDR=0 and wait counter=0, making every output 0.
REQ-032 clear during RD/WR SHALL abort the transaction immediately with no done/err pulse; the first post-reset cycle is IDLE.

Structure
REQ-033 State encodings, TIMEOUT=15 and the address width MEM_AW=9 SHALL live in the shared cpu_defs package/include.
REQ-034 MAR and MDR SHALL each instantiate the shared sub-module reg32 (32-bit register with enable and async clear); MAR uses the low 9 bits.

Verification
REQ-035 Reset: clear pulsed mid-RD -> mem_rd=0, BusMuxInMDR=0, mem_addr=0 and busy=0 immediately; no done pulse follows.
REQ-036 Read: MARin with bus=0x0000_0012, then Read; mem_ready=1 after 3 wait cycles with mem_rdata=0xDEAD_BEEF -> mem_addr=0x012, BusMuxInMDR=0xDEAD_BEEF, done high one cycle, err=0.
REQ-037 Write: MDRin with bus=0x1234_5678, MARin with bus=0x1FF, then Write; mem_ready on the first cycle -> mem_wr high one cycle, mem_wdata=0x1234_5678, done 2 cycles after Write.
REQ-038 Priority/ignore: Read and Write together -> only mem_rd asserts; MARin=1 with bus=0x055 while busy -> mem_addr unchanged.
REQ-039 Timeout: Read with mem_ready held at 0 -> done=1 and err=1 in the same cycle after 15 wait cycles, MDR retains its prior value.
REQ-040 Back-to-back: Read asserted in the FIN cycle is ignored; Read reasserted in the following IDLE cycle -> a new RD starts.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: memory-interface FSM states, address width and wait timeout.
package cpu_defs;

    localparam int         MEM_AW  = 9;
    localparam logic [3:0] TIMEOUT = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_FIN  = 2'd3
    } mem_state_e;

    // Bus loads into MAR/MDR are only honoured outside a transaction.
    function automatic logic bus_load_ok(input mem_state_e s);
        return (s == ST_IDLE) || (s == ST_FIN);
    endfunction

endpackage

// File: rtl/reg32.sv
// 32-bit register with load enable and asynchronous active-high clear.
module reg32 (
    input  logic        clock,
    input  logic        clear,
    input  logic        i_en,
    input  logic [31:0] i_d,
    output logic [31:0] o_q
);

    logic [31:0] r_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mdr_mem_if.sv
// MAR/MDR memory interface: single-cycle Read/Write requests run one transaction at a time,
// strobes rise the cycle after the request, done pulses the cycle after mem_ready or timeout.
module mdr_mem_if
    import cpu_defs::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       BusMuxInMDR,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    mem_state_e  r_state;
    logic [3:0]  r_wait;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_bus_ok;
    logic        w_rd_done;
    logic        w_mar_en;
    logic        w_mdr_en;
    logic [31:0] w_mar_d;
    logic [31:0] w_mdr_d;
    logic [31:0] w_mar_q;
    logic [31:0] w_mdr_q;
    logic        w_unused_mar;

    assign w_bus_ok  = bus_load_ok(r_state);
    assign w_rd_done = (r_state == ST_RD) && mem_ready;
    assign w_mar_en  = MARin && w_bus_ok;
    assign w_mar_d   = {{(32-MEM_AW){1'b0}}, BusMuxOut[MEM_AW-1:0]};
    // A read completion can only happen while busy, so it never races a bus load.
    assign w_mdr_en  = w_rd_done || (MDRin && w_bus_ok);
    assign w_mdr_d   = w_rd_done ? mem_rdata : BusMuxOut;

    reg32 u_mar (
        .clock (clock),
        .clear (clear),
        .i_en  (w_mar_en),
        .i_d   (w_mar_d),
        .o_q   (w_mar_q)
    );

    reg32 u_mdr (
        .clock (clock),
        .clear (clear),
        .i_en  (w_mdr_en),
        .i_d   (w_mdr_d),
        .o_q   (w_mdr_q)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_wait   <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wait <= '0;
                    if (Read) begin
                        r_state  <= ST_RD;
                        r_mem_rd <= 1'b1;
                        r_busy   <= 1'b1;
                    end else if (Write) begin
                        r_state  <= ST_WR;
                        r_mem_wr <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RD, ST_WR: begin
                    // Timeout fires on the edge where the wait count reaches TIMEOUT.
                    if (mem_ready || (r_wait == TIMEOUT - 4'd1)) begin
                        r_state  <= ST_FIN;
                        r_mem_rd <= 1'b0;
                        r_mem_wr <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= !mem_ready;
                    end
                    if (!mem_ready) begin
                        r_wait <= r_wait + 4'd1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_unused_mar = ^w_mar_q[31:MEM_AW];

    assign BusMuxInMDR = w_mdr_q;
    assign mem_wdata   = w_mdr_q;
    assign mem_addr    = w_mar_q[MEM_AW-1:0];
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Bench for mdr_mem_if: per-scenario tasks plus a scoreboard popped on every done pulse.
module tb_mdr_mem_if;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] BusMuxOut;
    logic        MARin;
    logic        MDRin;
    logic        Read;
    logic        Write;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] BusMuxInMDR;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] mdr;
        logic [8:0]  addr;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    mdr_mem_if dut (
        .clock       (clock),
        .clear       (clear),
        .BusMuxOut   (BusMuxOut),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .Read        (Read),
        .Write       (Write),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .BusMuxInMDR (BusMuxInMDR),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!clear && err === 1'b1 && done !== 1'b1) begin
            checks++; failures++;
            $display("FAIL err_without_done cyc=%0d", cyc);
        end
        if (!clear && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_done cyc=%0d err=%b", cyc, err);
            end else begin
                e = sb.pop_front();
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL done_cycle got=%0d exp=%0d", cyc, e.cyc);
                end
                checks++;
                if (err !== e.err) begin
                    failures++;
                    $display("FAIL done_err got=%b exp=%b", err, e.err);
                end
                checks++;
                if (BusMuxInMDR !== e.mdr) begin
                    failures++;
                    $display("FAIL done_mdr got=%h exp=%h", BusMuxInMDR, e.mdr);
                end
                checks++;
                if (mem_addr !== e.addr) begin
                    failures++;
                    $display("FAIL done_addr got=%h exp=%h", mem_addr, e.addr);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        BusMuxOut = '0; MARin = 1'b0; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
        mem_rdata = '0; mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        idle_inputs();
        repeat (2) tick();
        checks++;
        if ({BusMuxInMDR, mem_wdata, mem_addr} !== '0) begin
            failures++;
            $display("FAIL reset_data mdr=%h wdata=%h addr=%h exp=0", BusMuxInMDR, mem_wdata, mem_addr);
        end
        checks++;
        if ({mem_rd, mem_wr, busy, done, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000", {mem_rd, mem_wr, busy, done, err});
        end
        clear = 1'b0;
        tick();
        checks++;
        if ({mem_rd, mem_wr, busy, done} !== 4'b0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=0000", {mem_rd, mem_wr, busy, done});
        end
    endtask

    task automatic test_read();
        BusMuxOut = 32'h0000_0012; MARin = 1'b1;
        tick();
        MARin = 1'b0; BusMuxOut = '0;
        checks++;
        if (mem_addr !== 9'h012) begin
            failures++;
            $display("FAIL read_mar got=%h exp=012", mem_addr);
        end
        Read = 1'b1;
        sb.push_back('{mdr: 32'hDEAD_BEEF, addr: 9'h012, err: 1'b0, cyc: cyc + 5});
        tick();
        Read = 1'b0;
        checks++;
        if ({mem_rd, mem_wr, busy} !== 3'b101) begin
            failures++;
            $display("FAIL read_strobe got=%b exp=101", {mem_rd, mem_wr, busy});
        end
        repeat (3) tick();
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        checks++;
        if ({done, err, mem_rd, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL read_fin got=%b exp=1000", {done, err, mem_rd, busy});
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL read_done_width got=%b exp=0", done);
        end
    endtask

    task automatic test_write();
        BusMuxOut = 32'h1234_5678; MDRin = 1'b1;
        tick();
        MDRin = 1'b0; BusMuxOut = 32'h0000_01FF; MARin = 1'b1;
        tick();
        MARin = 1'b0; BusMuxOut = '0;
        checks++;
        if (mem_wdata !== 32'h1234_5678 || mem_addr !== 9'h1FF) begin
            failures++;
            $display("FAIL write_setup wdata=%h addr=%h exp=12345678/1ff", mem_wdata, mem_addr);
        end
        Write = 1'b1;
        sb.push_back('{mdr: 32'h1234_5678, addr: 9'h1FF, err: 1'b0, cyc: cyc + 2});
        tick();
        Write = 1'b0;
        checks++;
        if ({mem_wr, mem_rd} !== 2'b10) begin
            failures++;
            $display("FAIL write_strobe got=%b exp=10", {mem_wr, mem_rd});
        end
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_0000;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        checks++;
        if ({mem_wr, done, err} !== 3'b010 || mem_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL write_fin got=%b wdata=%h exp=010/12345678", {mem_wr, done, err}, mem_wdata);
        end
        tick();
    endtask

    task automatic test_priority();
        Read = 1'b1; Write = 1'b1;
        sb.push_back('{mdr: 32'hCAFE_F00D, addr: 9'h1FF, err: 1'b0, cyc: cyc + 3});
        tick();
        Read = 1'b0; Write = 1'b0;
        checks++;
        if ({mem_rd, mem_wr} !== 2'b10) begin
            failures++;
            $display("FAIL prio_strobe got=%b exp=10", {mem_rd, mem_wr});
        end
        MARin = 1'b1; MDRin = 1'b1; BusMuxOut = 32'h0000_0055;
        tick();
        MARin = 1'b0; MDRin = 1'b0; BusMuxOut = '0;
        checks++;
        if (mem_addr !== 9'h1FF || mem_wdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL busy_load_ignored addr=%h wdata=%h exp=1ff/12345678", mem_addr, mem_wdata);
        end
        mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        Read = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        sb.push_back('{mdr: 32'hCAFE_F00D, addr: 9'h1FF, err: 1'b1, cyc: cyc + 16});
        tick();
        Read = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL timeout_no_done waited=%0d pending=%0d exp=0", n, sb.size());
            sb.delete();
        end
        tick();
        mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        tick();
        checks++;
        if (BusMuxInMDR !== 32'hCAFE_F00D || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_ready_ignored mdr=%h busy=%b exp=cafef00d/0", BusMuxInMDR, busy);
        end
    endtask

    task automatic test_back_to_back();
        Read = 1'b1;
        sb.push_back('{mdr: 32'hA5A5_A5A5, addr: 9'h1FF, err: 1'b0, cyc: cyc + 2});
        tick();
        Read = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hA5A5_A5A5;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_fin got=%b exp=1", done);
        end
        Read = 1'b1;
        tick();
        checks++;
        if ({mem_rd, busy} !== 2'b00) begin
            failures++;
            $display("FAIL fin_read_ignored got=%b exp=00", {mem_rd, busy});
        end
        MDRin = 1'b1; BusMuxOut = 32'h0000_0077;
        sb.push_back('{mdr: 32'h5A5A_5A5A, addr: 9'h1FF, err: 1'b0, cyc: cyc + 2});
        tick();
        Read = 1'b0; MDRin = 1'b0; BusMuxOut = '0;
        checks++;
        if (mem_rd !== 1'b1 || BusMuxInMDR !== 32'h0000_0077) begin
            failures++;
            $display("FAIL b2b_restart rd=%b mdr=%h exp=1/00000077", mem_rd, BusMuxInMDR);
        end
        mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        tick();
        mem_ready = 1'b0; mem_rdata = '0;
        checks++;
        if (BusMuxInMDR !== 32'h5A5A_5A5A) begin
            failures++;
            $display("FAIL b2b_overwrite got=%h exp=5a5a5a5a", BusMuxInMDR);
        end
        tick();
    endtask

    task automatic test_clear_abort();
        int seen;
        MARin = 1'b1; BusMuxOut = 32'h0000_00AB;
        tick();
        MARin = 1'b0; BusMuxOut = '0; Read = 1'b1;
        tick();
        Read = 1'b0;
        checks++;
        if (mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL abort_setup rd=%b exp=1", mem_rd);
        end
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if ({mem_rd, busy} !== 2'b00 || BusMuxInMDR !== '0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL abort_async rd=%b busy=%b mdr=%h addr=%h exp=0", mem_rd, busy, BusMuxInMDR, mem_addr);
        end
        tick();
        clear = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        seen = 0;
        repeat (6) begin
            tick();
            if (done === 1'b1 || mem_rd === 1'b1) seen++;
        end
        mem_ready = 1'b0; mem_rdata = '0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_done seen=%0d exp=0", seen);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_priority();
        test_timeout();
        test_back_to_back();
        test_clear_abort();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drained pending=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
